// File: rtl/regfile_bus_master.sv
// Clocked initiator for the asynchronous register-file pin bus.
// Runs single-beat reads and writes with fixed setup/strobe/hold timing.
module regfile_bus_master #(
  parameter int Width    = 8,
  parameter int Depth    = 4,
  parameter int ReadWait = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Depth-1:0] req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  output logic             done_o,
  output logic [Width-1:0] rdata_o,
  output logic             cs_no,
  output logic             oe_o,
  output logic             ws_o,
  output logic [Depth-1:0] address_o,
  inout  wire  [Width-1:0] data_io
);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_ACCESS,
    TURN
  } state_t;

  localparam logic [3:0] RwLoad = 4'(ReadWait - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [Width-1:0] rdata_d;
  logic [Depth-1:0] addr_d;
  logic             drive_q, drive_d;
  logic             cs_d, oe_d, ws_d, done_d;
  logic             accept;

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;

  // Bus is released whenever the master is not in a write phase.
  assign data_io = drive_q ? wdata_q : {Width{1'bz}};

  // Next state, latched request fields and registered pin values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    addr_d  = address_o;
    rdata_d = rdata_o;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr_i;
          if (req_write_i) begin
            wdata_d = req_wdata_i;
            state_d = WR_SETUP;
          end else begin
            cnt_d   = RwLoad;
            state_d = RD_ACCESS;
          end
        end
      end
      WR_SETUP:  state_d = WR_STROBE;
      WR_STROBE: state_d = WR_HOLD;
      WR_HOLD: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      RD_ACCESS: begin
        if (cnt_q == 4'd0) begin
          rdata_d = data_io;
          state_d = TURN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cs_d    = (state_d == IDLE) || (state_d == TURN);
    oe_d    = (state_d == RD_ACCESS);
    ws_d    = (state_d == WR_STROBE);
    drive_d = (state_d == WR_SETUP) ||
              (state_d == WR_STROBE) ||
              (state_d == WR_HOLD);
  end

  // State and pin registers; reset releases the bus at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wdata_q   <= '0;
      rdata_o   <= '0;
      address_o <= '0;
      drive_q   <= 1'b0;
      cs_no     <= 1'b1;
      oe_o      <= 1'b0;
      ws_o      <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      rdata_o   <= rdata_d;
      address_o <= addr_d;
      drive_q   <= drive_d;
      cs_no     <= cs_d;
      oe_o      <= oe_d;
      ws_o      <= ws_d;
      done_o    <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_bus_master.sv
// Scoreboard bench for regfile_bus_master with a register-file model.
// Also exercises ReadWait=1 and ReadWait=15 instances.
module tb_regfile_bus_master;

  localparam int RW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       done;
  logic [7:0] rdata;
  logic       cs_n, oe, ws;
  logic [3:0] addr;
  wire  [7:0] data;

  logic [7:0] mem [16];
  logic [7:0] shadow [16];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int viol = 0;
  int ws_cnt = 0;
  logic [3:0] ws_a;
  logic [7:0] ws_d;
  logic prev_oe = 1'b0;

  typedef struct {
    bit         wr;
    logic [3:0] a;
    logic [7:0] d;
    int         acc;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  regfile_bus_master #(.Width(8), .Depth(4), .ReadWait(RW)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .done_o(done), .rdata_o(rdata),
    .cs_no(cs_n), .oe_o(oe), .ws_o(ws),
    .address_o(addr), .data_io(data)
  );

  assign data = (!cs_n && oe) ? mem[addr] : 8'hzz;
  always @(posedge ws) if (!cs_n) mem[addr] <= data;

  // ReadWait sweep instances
  logic       sw_valid [2];
  logic       sw_ready [2];
  logic       sw_done  [2];
  logic       sw_oe    [2];
  logic [7:0] sw_rdata [2];
  logic [3:0] sw_addr = 4'd9;

  for (genvar g = 0; g < 2; g++) begin : g_sw
    wire  [7:0] d;
    logic [7:0] m [16];
    logic       c, w;
    logic [3:0] a;
    initial for (int i = 0; i < 16; i++) m[i] = 8'hC0 ^ 8'(i);
    assign d = (!c && sw_oe[g]) ? m[a] : 8'hzz;
    always @(posedge w) if (!c) m[a] <= d;
    regfile_bus_master #(.Width(8), .Depth(4),
                         .ReadWait(g == 0 ? 1 : 15)) u_sw (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(sw_valid[g]), .req_ready_o(sw_ready[g]),
      .req_write_i(1'b0), .req_addr_i(sw_addr),
      .req_wdata_i(8'h00), .done_o(sw_done[g]),
      .rdata_o(sw_rdata[g]), .cs_no(c), .oe_o(sw_oe[g]),
      .ws_o(w), .address_o(a), .data_io(d)
    );
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge; returns at the negedge after accept.
  task automatic do_req(input bit w, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] ed,
                        output int acc);
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    acc = -1;
    for (int i = 0; i < 64; i++) begin
      if (req_ready) begin
        acc = cyc;
        e.wr = w; e.a = a; e.d = ed; e.acc = cyc;
        e.lat = w ? 4 : RW + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d,
                    output int acc);
    shadow[a] = d;
    do_req(1'b1, a, d, d, acc);
  endtask

  task automatic rd(input logic [3:0] a, output int acc);
    do_req(1'b0, a, 8'h00, shadow[a], acc);
  endtask

  task automatic sweep(input int k, input int rw);
    int acc, oe_n, lat;
    bit seen;
    sw_valid[k] = 1'b1;
    chk($sformatf("sw%0d_ready", rw), 32'(sw_ready[k]), 1);
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    sw_valid[k] = 1'b0;
    oe_n = 0;
    lat = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (sw_oe[k]) oe_n++;
      if (sw_done[k]) begin
        seen = 1;
        lat = cyc - acc;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("sw%0d_done_seen", rw), 32'(seen), 1);
    chk($sformatf("sw%0d_oe_cycles", rw), oe_n, rw);
    chk($sformatf("sw%0d_latency", rw), lat, rw + 1);
    chk($sformatf("sw%0d_rdata", rw), 32'(sw_rdata[k]), 32'h000000C9);
  endtask

  // Monitor: bus rules every cycle, scoreboard pop on done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!cs_n && $isunknown(data)) viol++;
      if (cs_n && data !== 8'hzz) viol++;
      if (prev_oe && !oe && !cs_n) viol++;
      if (oe && ws) viol++;
      prev_oe <= oe;
      if (ws) begin
        ws_cnt++;
        ws_a = addr;
        ws_d = data;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(done), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc - e.acc, e.lat);
          if (e.wr) begin
            chk("ws_cycles", ws_cnt, 1);
            chk("ws_addr", 32'(ws_a), 32'(e.a));
            chk("ws_data", 32'(ws_d), 32'(e.d));
          end else begin
            chk("ws_during_read", ws_cnt, 0);
            chk("rdata", 32'(rdata), 32'(e.d));
          end
          ws_cnt = 0;
        end
      end
    end
  end

  initial begin
    int acc, prev;
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 8'h10 + 8'(i);
      shadow[i] = 8'h10 + 8'(i);
    end
    sw_valid[0] = 1'b0;
    sw_valid[1] = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_oe", 32'(oe), 0);
    chk("rst_ws", 32'(ws), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data_z", 32'(data === 8'hzz), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_ready", 32'(req_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // reset during WR_SETUP
    do_req(1'b1, 4'd5, 8'hEE, 8'hEE, acc);
    chk("setup_cs_n", 32'(cs_n), 0);
    rst_n = 1'b0;
    #1;
    req_valid = 1'b0;
    chk("abort_cs_n", 32'(cs_n), 1);
    chk("abort_oe", 32'(oe), 0);
    chk("abort_ws", 32'(ws), 0);
    chk("abort_data_z", 32'(data === 8'hzz), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_ws_seen", ws_cnt, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'd5, acc);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);

    // write then read
    wr(4'd3, 8'hA5, acc);
    rd(4'd3, acc);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);

    // back-to-back writes then reads
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 8'(i) ^ 8'h5A, acc);
      if (prev >= 0) chk("b2b_spacing", acc - prev, 4);
      prev = acc;
    end
    for (int i = 0; i < 16; i++) rd(4'(i), acc);
    req_valid = 1'b0;

    // read then write to same address: turnaround
    rd(4'd7, acc);
    wr(4'd7, 8'h3C, acc);
    rd(4'd7, acc);
    req_valid = 1'b0;

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    chk("bus_violations", viol, 0);
    chk("mem7_model", 32'(mem[7]), 32'h3C);

    sweep(0, 1);
    sweep(1, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
